// File: rtl/mmu_pkg.sv
// Shared types and constants for the Sv48 page-table walker.
package mmu_pkg;

    localparam int LEVELS      = 4;
    localparam int VPN_SLICE   = 9;
    localparam int OFFSET_BITS = 12;
    localparam int PPN_BITS    = 44;
    localparam int XLEN        = 64;
    localparam int VPN_BITS    = LEVELS * VPN_SLICE;

    // PTE physical page number field
    localparam int PTE_PPN_LSB = 10;
    localparam int PTE_PPN_MSB = 53;

    // Leaf PTE bits [7:0] as handed back to the TLB
    typedef struct packed {
        logic d;
        logic a;
        logic g;
        logic u;
        logic x;
        logic w;
        logic r;
        logic v;
    } tlb_perm_bits;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } ptw_state_e;

    // PPN bits that a leaf found at this level takes from the VA instead of the PTE
    function automatic logic [PPN_BITS-1:0] low_vpn_mask(input logic [1:0] level);
        case (level)
            2'd1:    low_vpn_mask = 44'h000_0000_01FF;
            2'd2:    low_vpn_mask = 44'h000_0003_FFFF;
            2'd3:    low_vpn_mask = 44'h000_07FF_FFFF;
            default: low_vpn_mask = '0;
        endcase
    endfunction

endpackage

// File: rtl/ptw_arb2.sv
// Two-way round-robin arbiter; masked requesters are never granted.
module ptw_arb2 (
    input  logic [1:0] req,
    input  logic [1:0] mask,
    input  logic       last,
    output logic       grant_valid,
    output logic       grant_idx
);

    logic [1:0] elig;

    assign elig = req & ~mask;

    // On a tie the port that was not served last wins; otherwise the lone eligible port
    always_comb begin
        grant_valid = |elig;
        if (&elig) begin
            grant_idx = ~last;
        end else begin
            grant_idx = elig[1];
        end
    end

endmodule

// File: rtl/mmu_ptw.sv
// Sv48 page-table walker serving the D-TLB (port 0) and I-TLB (port 1).
//
// Handshakes: a memory request transfers on a cycle where mem_req_valid &&
// mem_req_ready, and mem_req_valid stays up until then. TLB requests are
// level-style: req_valid is held until the one-cycle resp_valid pulse, and
// the requesting port is masked for the cycle after its pulse.
module mmu_ptw
    import mmu_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [PPN_BITS-1:0] satp_ppn,
    input  logic                d_req_valid,
    input  logic [XLEN-1:0]     d_req_addr,
    output logic                d_resp_valid,
    output logic [XLEN-1:0]     d_resp_addr,
    output tlb_perm_bits        d_resp_perm_bits,
    input  logic                i_req_valid,
    input  logic [XLEN-1:0]     i_req_addr,
    output logic                i_resp_valid,
    output logic [XLEN-1:0]     i_resp_addr,
    output tlb_perm_bits        i_resp_perm_bits,
    output logic                mem_req_valid,
    output logic [XLEN-1:0]     mem_req_addr,
    input  logic                mem_req_ready,
    input  logic                mem_resp_valid,
    input  logic [XLEN-1:0]     mem_resp_data,
    output ptw_state_e          dbg_state_o
);

    ptw_state_e          state_q, state_d;
    logic                port_q, port_d;
    logic [1:0]          level_q, level_d;
    logic [PPN_BITS-1:0] base_q, base_d;
    logic [VPN_BITS-1:0] vpn_q, vpn_d;
    logic                rr_last_q, rr_last_d;
    logic [1:0]          cool_q, cool_d;
    logic [PPN_BITS-1:0] res_ppn_q, res_ppn_d;
    tlb_perm_bits        res_perm_q, res_perm_d;

    logic                grant_valid;
    logic                grant_idx;
    logic [VPN_SLICE-1:0] vpn_sel;
    logic [PPN_BITS-1:0] pte_ppn;
    logic [PPN_BITS-1:0] lvl_mask;
    logic                pte_v, pte_r, pte_w, pte_x;
    logic                unused_bits;

    ptw_arb2 u_arb (
        .req         ({i_req_valid, d_req_valid}),
        .mask        (cool_q),
        .last        (rr_last_q),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    assign pte_ppn  = mem_resp_data[PTE_PPN_MSB:PTE_PPN_LSB];
    assign pte_v    = mem_resp_data[0];
    assign pte_r    = mem_resp_data[1];
    assign pte_w    = mem_resp_data[2];
    assign pte_x    = mem_resp_data[3];
    assign lvl_mask = low_vpn_mask(level_q);

    assign unused_bits = ^{d_req_addr[XLEN-1:48], d_req_addr[OFFSET_BITS-1:0],
                           i_req_addr[XLEN-1:48], i_req_addr[OFFSET_BITS-1:0],
                           mem_resp_data[XLEN-1:PTE_PPN_MSB+1], mem_resp_data[9:8]};

    // VPN slice indexing the table at the current level
    always_comb begin
        case (level_q)
            2'd0:    vpn_sel = vpn_q[8:0];
            2'd1:    vpn_sel = vpn_q[17:9];
            2'd2:    vpn_sel = vpn_q[26:18];
            default: vpn_sel = vpn_q[35:27];
        endcase
    end

    // State and walk context registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            port_q     <= 1'b0;
            level_q    <= 2'd0;
            base_q     <= '0;
            vpn_q      <= '0;
            rr_last_q  <= 1'b1;
            cool_q     <= 2'b00;
            res_ppn_q  <= '0;
            res_perm_q <= '0;
        end else begin
            state_q    <= state_d;
            port_q     <= port_d;
            level_q    <= level_d;
            base_q     <= base_d;
            vpn_q      <= vpn_d;
            rr_last_q  <= rr_last_d;
            cool_q     <= cool_d;
            res_ppn_q  <= res_ppn_d;
            res_perm_q <= res_perm_d;
        end
    end

    // Walk sequencing: grant, issue PTE read, decode PTE, respond
    always_comb begin
        state_d    = state_q;
        port_d     = port_q;
        level_d    = level_q;
        base_d     = base_q;
        vpn_d      = vpn_q;
        rr_last_d  = rr_last_q;
        cool_d     = 2'b00;
        res_ppn_d  = res_ppn_q;
        res_perm_d = res_perm_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    port_d  = grant_idx;
                    vpn_d   = grant_idx ? i_req_addr[47:OFFSET_BITS] : d_req_addr[47:OFFSET_BITS];
                    level_d = 2'd3;
                    base_d  = satp_ppn;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (mem_req_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_resp_valid) begin
                    // Fault unless a valid leaf or a pointer above level 0 is found
                    res_ppn_d  = '0;
                    res_perm_d = '0;
                    state_d    = ST_RESP;
                    if (pte_v && !(!pte_r && pte_w)) begin
                        if (pte_r || pte_x) begin
                            if ((pte_ppn & lvl_mask) == '0) begin
                                res_ppn_d  = (pte_ppn & ~lvl_mask) | ({8'b0, vpn_q} & lvl_mask);
                                res_perm_d = tlb_perm_bits'(mem_resp_data[7:0]);
                            end
                        end else if (level_q != 2'd0) begin
                            base_d  = pte_ppn;
                            level_d = level_q - 2'd1;
                            state_d = ST_ISSUE;
                        end
                    end
                end
            end
            default: begin
                rr_last_d      = port_q;
                cool_d[port_q] = 1'b1;
                state_d        = ST_IDLE;
            end
        endcase
    end

    // Memory request and TLB response outputs, zero when inactive
    always_comb begin
        mem_req_valid    = (state_q == ST_ISSUE);
        mem_req_addr     = '0;
        if (mem_req_valid) begin
            mem_req_addr = {8'b0, base_q, 12'b0} + {52'b0, vpn_sel, 3'b0};
        end
        d_resp_valid     = (state_q == ST_RESP) && !port_q;
        i_resp_valid     = (state_q == ST_RESP) && port_q;
        d_resp_addr      = d_resp_valid ? {8'b0, res_ppn_q, 12'b0} : '0;
        i_resp_addr      = i_resp_valid ? {8'b0, res_ppn_q, 12'b0} : '0;
        d_resp_perm_bits = d_resp_valid ? res_perm_q : '0;
        i_resp_perm_bits = i_resp_valid ? res_perm_q : '0;
        dbg_state_o      = state_q;
    end

endmodule

// File: tb/tb_mmu_ptw.sv
// Bench for mmu_ptw: sparse page-table memory, randomized walks, reference walker.
module tb_mmu_ptw;
    import mmu_pkg::*;

    localparam int SB_W = 73;  // {port, resp_addr[63:0], perm[7:0]}

    logic         clk = 1'b0;
    logic         reset;
    logic [43:0]  satp_ppn;
    logic         d_req_valid, i_req_valid;
    logic [63:0]  d_req_addr, i_req_addr;
    logic         d_resp_valid, i_resp_valid;
    logic [63:0]  d_resp_addr, i_resp_addr;
    tlb_perm_bits d_resp_perm_bits, i_resp_perm_bits;
    logic         mem_req_valid, mem_req_ready, mem_resp_valid;
    logic [63:0]  mem_req_addr, mem_resp_data;
    ptw_state_e   dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int n_reads = 0;
    int resp_cnt = 0;
    int mem_mode = 0;        // 0 random timing, 1 fastest memory, 2 never respond
    bit late_req = 0;
    logic [63:0] late_data = '0;

    logic [SB_W-1:0] exp_q[$];
    logic [63:0] pt_mem [logic [63:0]];

    localparam logic [63:0] VA1 = 64'h0000_1234_5000;
    localparam logic [63:0] VA2 = 64'h0000_0040_5000;

    mmu_ptw dut (
        .clk              (clk),
        .reset            (reset),
        .satp_ppn         (satp_ppn),
        .d_req_valid      (d_req_valid),
        .d_req_addr       (d_req_addr),
        .d_resp_valid     (d_resp_valid),
        .d_resp_addr      (d_resp_addr),
        .d_resp_perm_bits (d_resp_perm_bits),
        .i_req_valid      (i_req_valid),
        .i_req_addr       (i_req_addr),
        .i_resp_valid     (i_resp_valid),
        .i_resp_addr      (i_resp_addr),
        .i_resp_perm_bits (i_resp_perm_bits),
        .mem_req_valid    (mem_req_valid),
        .mem_req_addr     (mem_req_addr),
        .mem_req_ready    (mem_req_ready),
        .mem_resp_valid   (mem_resp_valid),
        .mem_resp_data    (mem_resp_data),
        .dbg_state_o      (dbg_state)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mem_rd(input logic [63:0] a);
        return pt_mem.exists(a) ? pt_mem[a] : 64'd0;
    endfunction

    function automatic logic [63:0] rand_ppn();
        return {20'b0, 12'($urandom), 32'($urandom)};
    endfunction

    function automatic logic [63:0] pte_addr(input logic [63:0] base, input logic [63:0] va, input int lvl);
        return (base << 12) + ((va >> (12 + 9 * lvl)) & 64'h1FF) * 8;
    endfunction

    task automatic set_pte(input logic [63:0] base, input logic [63:0] va, input int lvl, input logic [63:0] pte);
        pt_mem[pte_addr(base, va, lvl)] = pte;
    endtask

    // reference walker: Sv48 rules applied directly to the memory image
    function automatic void ref_walk(input logic [63:0] satp, input logic [63:0] va,
                                     output logic [63:0] addr, output logic [7:0] perm, output int reads);
        logic [63:0] base, pte, ppn, span, vpn_all;
        bit done;
        base = satp; addr = 0; perm = 0; reads = 0; done = 0;
        vpn_all = (va >> 12) & ((64'd1 << 36) - 1);
        for (int lvl = 3; lvl >= 0 && !done; lvl--) begin
            pte = mem_rd(pte_addr(base, va, lvl));
            reads++;
            ppn  = (pte >> 10) & ((64'd1 << 44) - 1);
            span = 64'd1 << (9 * lvl);
            if (!pte[0] || (!pte[1] && pte[2])) begin
                done = 1;
            end else if (pte[1] || pte[3]) begin
                done = 1;
                if (ppn % span == 0) begin
                    addr = (ppn + vpn_all % span) << 12;
                    perm = pte[7:0];
                end
            end else if (lvl == 0) begin
                done = 1;
            end else begin
                base = ppn;
            end
        end
    endfunction

    // random path of PTEs along the walk of va
    task automatic build_path(input logic [63:0] satp, input logic [63:0] va);
        logic [63:0] base, ppn, junk;
        logic [7:0]  perm;
        int kind;
        bit stop;
        base = satp; stop = 0;
        for (int lvl = 3; lvl >= 0 && !stop; lvl--) begin
            kind = $urandom_range(0, 9);
            junk = 64'($urandom) << 54;
            if (kind == 0) begin
                set_pte(base, va, lvl, {32'($urandom), 32'($urandom)} & ~64'h1);
                stop = 1;
            end else if (kind == 1) begin
                set_pte(base, va, lvl, (rand_ppn() << 10) | 64'h5 | junk);
                stop = 1;
            end else if (kind <= 4) begin
                ppn = rand_ppn();
                if (kind != 4) ppn = ppn & ~((64'd1 << (9 * lvl)) - 1);
                perm = 8'($urandom);
                if (kind == 3) perm = (perm | 8'h09) & ~8'h06;
                else perm = perm | 8'h03;
                set_pte(base, va, lvl, (ppn << 10) | 64'(perm) | junk);
                stop = 1;
            end else begin
                ppn = rand_ppn();
                set_pte(base, va, lvl, (ppn << 10) | 64'h1 | (64'($urandom) & 64'hF0) | junk);
                base = ppn;
            end
        end
    endtask

    // memory responder: records handshakes, returns PTEs after a latency
    initial begin : mem_model
        bit pending;
        logic [63:0] pend_addr;
        int lat;
        pending = 0; pend_addr = 0; lat = 0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = 0;
        forever begin
            @(negedge clk);
            if (reset) pending = 0;
            if (mem_req_valid && mem_req_ready) begin
                pending   = 1;
                pend_addr = mem_req_addr;
                lat       = (mem_mode == 1) ? 0 : $urandom_range(0, 2);
                n_reads++;
            end
            @(posedge clk);
            #1;
            mem_resp_valid = 0;
            if (late_req) begin
                mem_resp_valid = 1;
                mem_resp_data  = late_data;
                late_req       = 0;
            end else if (pending && mem_mode != 2) begin
                if (lat == 0) begin
                    mem_resp_valid = 1;
                    mem_resp_data  = mem_rd(pend_addr);
                    pending        = 0;
                end else begin
                    lat--;
                end
            end else if (!pending && mem_mode == 0 && $urandom_range(0, 7) == 0) begin
                mem_resp_valid = 1;
                mem_resp_data  = {32'($urandom), 32'($urandom)} | 64'h3;
            end
            mem_req_ready = (mem_mode == 1) ? 1'b1 : ($urandom_range(0, 3) != 0);
        end
    end

    // scoreboard: every response pulse must match the head of exp_q
    always @(negedge clk) begin
        logic [SB_W-1:0] obs, exp;
        if (d_resp_valid || i_resp_valid) begin
            resp_cnt++;
            check_eq("resp_one_port", d_resp_valid && i_resp_valid, 0);
            obs = i_resp_valid ? {1'b1, i_resp_addr, i_resp_perm_bits}
                               : {1'b0, d_resp_addr, d_resp_perm_bits};
            check_eq("resp_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                exp = exp_q.pop_front();
                check_eq("resp_port_addr_perm", obs, exp);
            end
        end
    end

    task automatic apply_reset();
        @(posedge clk);
        #1;
        reset = 1;
        d_req_valid = 0;
        i_req_valid = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
    endtask

    task automatic wait_resp(input bit port, output bit got, output int when);
        got = 0; when = 0;
        for (int k = 0; k < 400 && !got; k++) begin
            @(negedge clk);
            if (port ? i_resp_valid : d_resp_valid) begin
                got  = 1;
                when = cyc;
            end
        end
    endtask

    // one walk from a single requester; called just after a posedge
    task automatic do_walk(input bit port, input logic [63:0] va, input logic [43:0] satp,
                           input logic [63:0] e_addr, input logic [7:0] e_perm, input int e_reads,
                           input bit hold, output int lat);
        int r0, c0, when;
        bit got;
        satp_ppn = satp;
        exp_q.push_back({port, e_addr, e_perm});
        r0 = n_reads;
        if (port) begin i_req_addr = va; i_req_valid = 1; end
        else      begin d_req_addr = va; d_req_valid = 1; end
        c0 = cyc;
        wait_resp(port, got, when);
        check_eq(port ? "i_resp_seen" : "d_resp_seen", got, 1);
        lat = when - c0;
        @(posedge clk);
        #1;
        if (hold) begin
            @(posedge clk);
            #1;
        end
        if (port) i_req_valid = 0;
        else      d_req_valid = 0;
        check_eq("mem_read_count", n_reads - r0, e_reads);
    endtask

    initial begin : main
        int lat, r0, rc0, td, ti, c0, e_reads;
        bit gd, gi;
        logic [63:0] e_addr, va, satp;
        logic [7:0]  e_perm;
        bit port;

        reset = 1; satp_ppn = 0;
        d_req_valid = 0; d_req_addr = 0;
        i_req_valid = 0; i_req_addr = 0;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_state", dbg_state, ST_IDLE);
        check_eq("rst_mem_req_valid", mem_req_valid, 0);
        check_eq("rst_mem_req_addr", mem_req_addr, 0);
        check_eq("rst_d_resp", {d_resp_valid, d_resp_addr, d_resp_perm_bits}, 0);
        check_eq("rst_i_resp", {i_resp_valid, i_resp_addr, i_resp_perm_bits}, 0);
        @(posedge clk);
        #1;
        reset = 0;

        // shared tables under root 0x100: VA1 is a 4KB page, VA2 a 2MB superpage
        set_pte(64'h100, VA1, 3, (64'h101 << 10) | 64'h1);
        set_pte(64'h101, VA1, 2, (64'h102 << 10) | 64'h1);
        set_pte(64'h102, VA1, 1, (64'h103 << 10) | 64'h1);
        set_pte(64'h103, VA1, 0, (64'hABCDE << 10) | 64'hCF);
        set_pte(64'h102, VA2, 1, (64'h200 << 10) | 64'hCF);
        set_pte(64'h600, VA1, 3, (64'h55 << 10) | 64'h5);

        // 4-level walk with the fastest memory
        mem_mode = 1;
        do_walk(0, VA1, 44'h100, 64'hABCDE000, 8'hCF, 4, 0, lat);
        check_eq("min_latency", lat, 9);

        mem_mode = 0;
        do_walk(1, VA1, 44'h100, 64'hABCDE000, 8'hCF, 4, 0, lat);
        do_walk(0, VA2, 44'h100, 64'h205000, 8'hCF, 3, 0, lat);
        set_pte(64'h102, VA2, 1, (64'h201 << 10) | 64'hCF);
        do_walk(1, VA2, 44'h100, 64'h0, 8'h00, 3, 0, lat);
        set_pte(64'h102, VA2, 1, (64'h200 << 10) | 64'hCF);
        do_walk(0, VA1, 44'h500, 64'h0, 8'h00, 1, 0, lat);
        do_walk(1, VA1, 44'h600, 64'h0, 8'h00, 1, 0, lat);

        // simultaneous requests right after reset: D first, I back to back
        mem_mode = 1;
        apply_reset();
        satp_ppn = 44'h100;
        exp_q.push_back({1'b0, 64'hABCDE000, 8'hCF});
        exp_q.push_back({1'b1, 64'h205000, 8'hCF});
        d_req_addr = VA1; i_req_addr = VA2;
        d_req_valid = 1; i_req_valid = 1;
        c0 = cyc;
        wait_resp(0, gd, td);
        check_eq("tie_d_seen", gd, 1);
        @(posedge clk);
        #1;
        d_req_valid = 0;
        wait_resp(1, gi, ti);
        check_eq("tie_i_seen", gi, 1);
        @(posedge clk);
        #1;
        i_req_valid = 0;
        check_eq("tie_d_latency", td - c0, 9);
        check_eq("tie_i_after_d", ti - td, 8);

        // D held for the cycle after its response: no second walk
        mem_mode = 0;
        do_walk(0, VA2, 44'h100, 64'h205000, 8'hCF, 3, 1, lat);
        r0 = n_reads; rc0 = resp_cnt;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check_eq("hold_no_regrant_reads", n_reads - r0, 0);
        check_eq("hold_no_regrant_resp", resp_cnt - rc0, 0);
        check_eq("hold_state_idle", dbg_state, ST_IDLE);
        @(posedge clk);
        #1;

        // reset during WAIT, then a late memory response
        mem_mode = 2;
        satp_ppn = 44'h100;
        d_req_addr = VA1;
        d_req_valid = 1;
        gd = 0;
        for (int k = 0; k < 60 && !gd; k++) begin
            @(negedge clk);
            if (dbg_state == ST_WAIT) gd = 1;
        end
        check_eq("abort_reached_wait", gd, 1);
        @(posedge clk);
        #1;
        reset = 1;
        d_req_valid = 0;
        @(posedge clk);
        #1;
        reset = 0;
        rc0 = resp_cnt;
        r0 = n_reads;
        late_data = (64'hABCDE << 10) | 64'hCF;
        late_req = 1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check_eq("abort_no_resp", resp_cnt - rc0, 0);
        check_eq("abort_no_reads", n_reads - r0, 0);
        check_eq("abort_state_idle", dbg_state, ST_IDLE);
        @(posedge clk);
        #1;
        mem_mode = 0;
        do_walk(0, VA1, 44'h100, 64'hABCDE000, 8'hCF, 4, 0, lat);

        // randomized walks against the reference walker
        for (int t = 0; t < 40; t++) begin
            port = 1'($urandom_range(0, 1));
            va   = {16'b0, 16'($urandom), 32'($urandom)};
            satp = rand_ppn();
            build_path(satp, va);
            ref_walk(satp, va, e_addr, e_perm, e_reads);
            do_walk(port, va, satp[43:0], e_addr, e_perm, e_reads, 0, lat);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        repeat (5) @(posedge clk);
        @(negedge clk);
        check_eq("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
